uart_rs232_rx: RTL and testbench



---
 rtl/uart_rs232_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rs232_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rs232_rx.sv
`timescale 1ns/1ps
// uart_rs232_rx
//   RS-232 receiver using a shared 16x oversampling baud Tick. Recovers frames
//   of start + NBits data (LSB first) + optional even parity + one stop bit,
//   and presents each word on RxData with a one-cycle RxDone strobe.
//
//   Optional feature macro: UART_RX_PARITY_EN (defined: expect an even parity
//   bit after the data bits; undefined: no parity bit, ParityErr tied to 0).
//
// Ports:
//   Clk       in   system clock, rising edge
//   Rst       in   asynchronous active-high reset
//   Tick      in   baud enable, OVERSAMPLE pulses per bit
//   Rx        in   serial line (idle high), asynchronous to Clk
//   NBits     in   data bits per frame, 1..8 (0 or >8 means 8)
//   RxData    out  last received word, right-aligned, upper bits 0
//   RxDone    out  one-cycle strobe when RxData updates
//   FrameErr  out  stop bit sampled low in the last frame
//   ParityErr out  parity mismatch in the last frame
//   Busy      out  receiver not idle
module uart_rs232_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  input  logic       Rx,
  input  logic [3:0] NBits,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       FrameErr,
  output logic       ParityErr,
  output logic       Busy
);

  localparam logic [3:0] CNT_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       rx_meta_q, rx_s_q;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] last_q, last_d;   // index of the final data bit, latched at start
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       ferr_q, ferr_d;
  logic       perr_q, perr_d;
`ifdef UART_RX_PARITY_EN
  logic       par_q, par_d;
`endif

  // State register (plus datapath flops)
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q <= Rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // Next-state logic; everything except the synchronizer only moves on Tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    if (Tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = '0;   // cleared so unused upper bits read back as 0
            last_d  = (NBits == 4'd0 || NBits > 4'd8) ? 3'd7 : 3'(NBits - 4'd1);
            state_d = START;
          end
        end
        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            shift_d[idx_q] = rx_s_q;
            cnt_d          = '0;
            idx_d          = idx_q + 3'd1;
            if (idx_q == last_q) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            par_d   = rx_s_q;
            cnt_d   = '0;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
`endif
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            data_d  = shift_q;
            ferr_d  = !rx_s_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^shift_q) ^ par_q;
`else
            perr_d  = 1'b0;
`endif
            done_d  = 1'b1;
            cnt_d   = '0;
            // Leaving at mid-stop-bit lets a back-to-back start edge be seen
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    RxData    = data_q;
    RxDone    = done_q;
    FrameErr  = ferr_q;
    ParityErr = perr_q;
    Busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_uart_rs232_rx.sv
`timescale 1ns/1ps
module tb_uart_rs232_rx;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Tick = 1'b0;
  logic       Rx = 1'b1;
  logic [3:0] NBits = 4'd8;
  logic [7:0] RxData;
  logic       RxDone;
  logic       FrameErr;
  logic       ParityErr;
  logic       Busy;

  uart_rs232_rx #(.OVERSAMPLE(16)) dut (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .Rx(Rx), .NBits(NBits),
    .RxData(RxData), .RxDone(RxDone), .FrameErr(FrameErr),
    .ParityErr(ParityErr), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Tick every 4 Clk, changed on the falling edge so it is stable at posedge
  int unsigned tick_div = 0;
  always @(negedge Clk) begin
    tick_div = (tick_div == 3) ? 0 : tick_div + 1;
    Tick = (tick_div == 0);
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;
  exp_t sb[$];
  int   done_cnt = 0;
  int   pushed = 0;
  logic prev_done = 1'b0;

  // Scoreboard consumer
  always @(negedge Clk) begin
    if (RxDone) begin
      exp_t e;
      done_cnt++;
      check("done_not_consecutive", prev_done, 1'b0);
      check("busy_low_with_done", Busy, 1'b0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("rx_data", RxData, e.data);
        check("frame_err", FrameErr, e.ferr);
        check("parity_err", ParityErr, e.perr);
      end
    end
    prev_done = RxDone;
  end

  // Count n Tick-qualified rising edges, then step just past the edge
  task automatic wait_ticks(input int unsigned n);
    repeat (n) begin
      do @(posedge Clk); while (!Tick);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input logic bad_par, input bit push);
    int unsigned nb;
    logic [7:0]  exp_d;
    exp_t        e;
    nb = (NBits == 4'd0 || NBits > 4'd8) ? 8 : int'(NBits);
    exp_d = '0;
    for (int unsigned i = 0; i < nb; i++) exp_d[i] = data[i];
    if (push) begin
      e.data = exp_d;
      e.ferr = !stop;
`ifdef UART_RX_PARITY_EN
      e.perr = bad_par;
`else
      e.perr = 1'b0;
`endif
      sb.push_back(e);
      pushed++;
    end
    Rx = 1'b0;
    wait_ticks(16);
    for (int unsigned i = 0; i < nb; i++) begin
      Rx = data[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    Rx = (^exp_d) ^ bad_par;
    wait_ticks(16);
`endif
    Rx = stop;
    wait_ticks(16);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rxdata"}, RxData, 8'h00);
    check({tag, "_rxdone"}, RxDone, 1'b0);
    check({tag, "_ferr"}, FrameErr, 1'b0);
    check({tag, "_perr"}, ParityErr, 1'b0);
    check({tag, "_busy"}, Busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] held;
    int         dc;

    // Reset
    Rst = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    Rst = 1'b0;
    wait_ticks(4);

    // 8-bit frame 0xA5
    NBits = 4'd8;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    wait_ticks(4);
    check("a5_busy_after", Busy, 1'b0);
    check("a5_done_count", done_cnt, 1);

    // 5-bit frames, then back-to-back 0x1F / 0x00
    NBits = 4'd5;
    send_frame(8'h15, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);   // upper bits must be discarded -> 0x1F
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    wait_ticks(4);
    check("nb5_done_count", done_cnt, 4);

    // NBits=0 behaves as 8
    NBits = 4'd0;
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
    wait_ticks(4);

    // False start: low for 4 Ticks only
    NBits = 4'd8;
    held = RxData;
    dc = done_cnt;
    Rx = 1'b0;
    wait_ticks(4);
    check("false_start_busy_high", Busy, 1'b1);
    Rx = 1'b1;
    wait_ticks(12);
    check("false_start_busy_low", Busy, 1'b0);
    check("false_start_data_held", RxData, held);
    check("false_start_no_done", done_cnt, dc);

    // Framing error frame, idle gap, then good frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    Rx = 1'b1;
    wait_ticks(16);
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    wait_ticks(4);

    // Reset in the middle of data bit 3
    dc = done_cnt;
    Rx = 1'b0;
    wait_ticks(16);
    for (int unsigned i = 0; i < 4; i++) begin
      Rx = (i % 2 == 0);
      wait_ticks(i == 3 ? 8 : 16);
    end
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check_reset_outputs("midframe_reset");
    Rx = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    wait_ticks(16);
    check("midframe_reset_no_done", done_cnt, dc);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    wait_ticks(4);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    wait_ticks(4);
`endif

    wait_ticks(8);
    check("scoreboard_empty", sb.size(), 0);
    check("total_done_count", done_cnt, pushed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
